// File: rtl/frame_dram_writer_if.sv
// rtl/frame_dram_writer_if.sv - pixel stream and DRAM write port bundle for frame_dram_writer
// Signals:
//   frame_start, pix_valid, pix_data, pix_ready : pixel stream with frame restart marker
//   wr_full                                     : DRAM write path backpressure
//   ctrl_in, ctrl_we                            : burst command {len[39:32], addr[31:0]}
//   data_in, data_we                            : burst data beat {strb[35:32], data[31:0]}
//   frame_done, overflow                        : end-of-frame pulse, sticky error flag
// Modports: master = pixel source / DRAM side, slave = the writer.
interface frame_dram_writer_if;
  logic        frame_start;
  logic        pix_valid;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        wr_full;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we;
  logic        frame_done;
  logic        overflow;

  modport master (
    output frame_start, pix_valid, pix_data, wr_full,
    input  pix_ready, data_in, data_we, ctrl_in, ctrl_we, frame_done, overflow
  );

  modport slave (
    input  frame_start, pix_valid, pix_data, wr_full,
    output pix_ready, data_in, data_we, ctrl_in, ctrl_we, frame_done, overflow
  );
endinterface

// File: rtl/frame_dram_writer.sv
// rtl/frame_dram_writer.sv - buffers a 24-bit pixel stream and writes it to DRAM in fixed bursts
// Ports:
//   clk, rst            : single clock, synchronous active-high reset
//   bus.frame_start     : next accepted pixel is (0,0)
//   bus.pix_valid/pix_data/pix_ready : pixel stream {R,G,B}
//   bus.wr_full         : DRAM write path cannot take ctrl/data this cycle
//   bus.ctrl_in/ctrl_we : burst command {len = BURST_LEN-1, byte addr}
//   bus.data_in/data_we : data beat {4'hF, pixel, 8'h00}
//   bus.frame_done      : pulse once the last burst of a frame has been issued
//   bus.overflow        : sticky, frame_start seen while another is pending
module frame_dram_writer #(
  parameter int unsigned X_SIZE    = 1280,
  parameter int unsigned Y_SIZE    = 720,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned BURST_LEN = 16
) (
  input  logic               clk,
  input  logic               rst,
  frame_dram_writer_if.slave bus
);

  localparam int unsigned DEPTH = 2 * BURST_LEN;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [31:0]   TOTAL     = 32'(X_SIZE * Y_SIZE);
  localparam logic [31:0]   STEP      = 32'(BURST_LEN);
  localparam logic [CW-1:0] CNT_BURST = CW'(BURST_LEN);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_BEAT = AW'(BURST_LEN - 1);
  localparam logic [7:0]    LEN_FIELD = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, FLUSH} state_t;

  state_t        state, next_state;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, beat;
  logic [CW-1:0] count;
  logic [31:0]   word_idx;
  logic [31:0]   pix_cnt;
  logic          pending;
  logic          done_pulse;
  logic          overflow_flag;
  logic          accept, push, pop, burst_end;

  // A frame_start on the input blocks the pixel in the same cycle so that
  // pixel can never be counted against the frame that is being abandoned.
  assign bus.pix_ready = (count != CNT_FULL) && (state != FLUSH) && !pending && !bus.frame_start;
  assign accept        = bus.pix_valid && bus.pix_ready;
  // Pixels past the end of the frame are handshaked but dropped.
  assign push          = accept && (pix_cnt < TOTAL);
  assign pop           = (state == DATA) && !bus.wr_full && !rst;
  assign burst_end     = pop && (beat == LAST_BEAT);
  assign bus.frame_done = done_pulse;
  assign bus.overflow   = overflow_flag;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    bus.ctrl_we = 1'b0;
    bus.data_we = 1'b0;
    bus.ctrl_in = '0;
    bus.data_in = '0;
    case (state)
      IDLE: begin
        if (bus.frame_start)
          next_state = FLUSH;
        else if (count >= CNT_BURST && !bus.wr_full)
          next_state = CMD;
      end
      CMD: begin
        bus.ctrl_we = !rst;
        bus.ctrl_in = rst ? '0 : {LEN_FIELD, BASE_ADDR + (word_idx << 2)};
        next_state  = DATA;
      end
      DATA: begin
        bus.data_we = pop;
        bus.data_in = pop ? {4'hF, mem[rd_ptr], 8'h00} : '0;
        // A frame_start seen during the burst waits until the last beat.
        if (burst_end)
          next_state = (pending || bus.frame_start) ? FLUSH : IDLE;
      end
      FLUSH: begin
        next_state = bus.frame_start ? FLUSH : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.pix_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      beat          <= '0;
      count         <= '0;
      word_idx      <= '0;
      pix_cnt       <= '0;
      pending       <= 1'b0;
      done_pulse    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (bus.frame_start && pending) overflow_flag <= 1'b1;

      if (next_state == FLUSH)
        pending <= 1'b0;
      else if (bus.frame_start && (state == CMD || state == DATA))
        pending <= 1'b1;

      if (state == FLUSH) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        beat     <= '0;
        count    <= '0;
        word_idx <= '0;
        pix_cnt  <= '0;
      end else begin
        if (push) begin
          wr_ptr  <= wr_ptr + 1'b1;
          pix_cnt <= pix_cnt + 32'd1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
          beat   <= burst_end ? '0 : beat + 1'b1;
        end
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
        if (burst_end) begin
          if (word_idx + STEP == TOTAL) begin
            word_idx   <= '0;
            done_pulse <= 1'b1;
          end else begin
            word_idx <= word_idx + STEP;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_dram_writer.sv
// tb/tb_frame_dram_writer.sv - self-checking bench for frame_dram_writer
module tb_frame_dram_writer;
  localparam int X = 32, Y = 2, BL = 16, TOTAL = X * Y;
  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct packed {logic is_ctrl; logic [39:0] val;} ev_t;
  typedef struct {int n; int full_pct; bit start_valid; int exp_bursts; int exp_done;} row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_dram_writer_if bus();
  frame_dram_writer #(.X_SIZE(X), .Y_SIZE(Y), .BASE_ADDR(BASE), .BURST_LEN(BL))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0, errors = 0;
  ev_t exp_q[$];
  logic [23:0] pend_q[$];
  int fpix = 0, exp_done = 0;
  int n_ctrl = 0, n_data = 0, n_done = 0;
  logic [31:0] last_addr = '0;
  logic [23:0] next_pix = 24'd1;
  ev_t mon_ev;
  bit last_acc, s_ready, s_data_we, s_ctrl_we, s_done, s_overflow;
  logic [35:0] s_data_in;
  logic [39:0] s_ctrl_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: pixels of a frame fill bursts in arrival order; a burst
  // exists only once BL pixels of the frame are in hand, and only the first
  // TOTAL pixels of a frame count.
  task automatic model_accept(input logic [23:0] p);
    if (fpix < TOTAL) begin
      pend_q.push_back(p);
      fpix++;
      if (pend_q.size() == BL) begin
        exp_q.push_back('{1'b1, {8'(BL - 1), BASE + 32'((fpix - BL) * 4)}});
        for (int i = 0; i < BL; i++) exp_q.push_back('{1'b0, {4'h0, 4'hF, pend_q[i], 8'h00}});
        pend_q.delete();
        if (fpix == TOTAL) exp_done++;
      end
    end
  endtask

  task automatic model_frame_start();
    fpix = 0;
    pend_q.delete();
  endtask

  task automatic model_reset();
    model_frame_start();
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ctrl_we || bus.data_we) begin
        check("we_exclusive", 64'(bus.ctrl_we & bus.data_we), 64'd0);
        if (bus.data_we) check("data_we_under_full", 64'(bus.wr_full), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: ctrl_we=%0b ctrl_in=0x%0h data_in=0x%0h expected no write",
                   bus.ctrl_we, bus.ctrl_in, bus.data_in);
        end else begin
          mon_ev = exp_q.pop_front();
          check("write_kind", 64'(bus.ctrl_we), 64'(mon_ev.is_ctrl));
          if (bus.ctrl_we) check("ctrl_in", 64'(bus.ctrl_in), 64'(mon_ev.val));
          else             check("data_in", 64'(bus.data_in), 64'(mon_ev.val));
        end
        if (bus.ctrl_we) begin
          n_ctrl++;
          last_addr = bus.ctrl_in[31:0];
        end
        if (bus.data_we) n_data++;
      end
      if (bus.frame_done) n_done++;
    end
  end

  task automatic step();
    @(negedge clk);
    last_acc   = bus.pix_valid && bus.pix_ready && !rst;
    s_ready    = bus.pix_ready;
    s_data_we  = bus.data_we;
    s_ctrl_we  = bus.ctrl_we;
    s_done     = bus.frame_done;
    s_overflow = bus.overflow;
    s_data_in  = bus.data_in;
    s_ctrl_in  = bus.ctrl_in;
    if (rst) model_reset();
    else begin
      if (bus.frame_start) begin
        check("ready_with_start", 64'(bus.pix_ready), 64'd0);
        model_frame_start();
      end
      if (last_acc) model_accept(bus.pix_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit with_valid);
    bus.frame_start = 1'b1;
    bus.pix_valid   = with_valid;
    bus.pix_data    = next_pix;
    step();
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
  endtask

  task automatic send_pixels(input int n, input int vpct, input int fpct, input bit rnd);
    int got = 0;
    int budget = n * 40 + 400;
    while (got < n && budget > 0) begin
      bus.pix_valid = int'($urandom_range(99)) < vpct;
      bus.wr_full   = int'($urandom_range(99)) < fpct;
      bus.pix_data  = next_pix;
      step();
      if (last_acc) begin
        got++;
        next_pix = rnd ? 24'($urandom) : next_pix + 24'd1;
      end
      budget--;
    end
    bus.pix_valid = 1'b0;
    bus.wr_full   = 1'b0;
    check("send_complete", 64'(got), 64'(n));
  endtask

  task automatic drain(input int fpct);
    int budget = 4000;
    while (exp_q.size() != 0 && budget > 0) begin
      bus.wr_full = int'($urandom_range(99)) < fpct;
      step();
      budget--;
    end
    bus.wr_full = 1'b0;
    repeat (4) step();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_beats(input int base, input int k);
    int budget = 200;
    while (n_data - base < k && budget > 0) begin
      step();
      budget--;
    end
    check("wait_beats", 64'(n_data - base >= k), 64'd1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: time limit reached with %0d checks", checks);
    $fatal(1);
  end

  initial begin
    row_t rows[7];
    int c0, d0, f0, e0, got, n;
    rows[0] = '{64, 0, 1'b0, 4, 1};
    rows[1] = '{66, 0, 1'b1, 4, 1};
    rows[2] = '{48, 20, 1'b0, 3, 0};
    rows[3] = '{63, 0, 1'b0, 3, 0};
    rows[4] = '{15, 0, 1'b0, 0, 0};
    rows[5] = '{80, 30, 1'b1, 4, 1};
    rows[6] = '{16, 50, 1'b0, 1, 0};

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pix_data    = '0;
    bus.wr_full     = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_data_we", 64'(s_data_we), 64'd0);
    check("rst_ctrl_we", 64'(s_ctrl_we), 64'd0);
    rst = 1'b0;
    step();
    check("post_rst_ready", 64'(s_ready), 64'd1);
    check("post_rst_data_we", 64'(s_data_we), 64'd0);
    check("post_rst_ctrl_we", 64'(s_ctrl_we), 64'd0);
    check("post_rst_done", 64'(s_done), 64'd0);
    check("post_rst_overflow", 64'(s_overflow), 64'd0);
    check("post_rst_data_in", 64'(s_data_in), 64'd0);
    check("post_rst_ctrl_in", 64'(s_ctrl_in), 64'd0);

    // Frame table: pixel count, wr_full density, start-with-valid, expected bursts and done pulses
    for (int i = 0; i < 7; i++) begin
      c0 = n_ctrl; d0 = n_data; f0 = n_done;
      pulse_start(rows[i].start_valid);
      send_pixels(rows[i].n, 100, rows[i].full_pct, 1'b0);
      drain(0);
      check("tbl_bursts", 64'(n_ctrl - c0), 64'(rows[i].exp_bursts));
      check("tbl_beats", 64'(n_data - d0), 64'(rows[i].exp_bursts * BL));
      check("tbl_done", 64'(n_done - f0), 64'(rows[i].exp_done));
      if (i == 0) check("first_frame_last_addr", 64'(last_addr), 64'(BASE + 32'hC0));
    end

    // FIFO fill against a permanently full write path
    f0 = n_done;
    pulse_start(1'b0);
    bus.wr_full = 1'b1;
    bus.pix_valid = 1'b1;
    got = 0;
    repeat (40) begin
      bus.pix_data = next_pix;
      step();
      if (last_acc) begin
        got++;
        next_pix = next_pix + 24'd1;
      end
    end
    check("fill_accepted", 64'(got), 64'd32);
    check("fill_ready_low", 64'(s_ready), 64'd0);
    bus.pix_valid = 1'b0;
    send_pixels(32, 100, 0, 1'b0);
    drain(0);
    check("fill_done", 64'(n_done - f0), 64'd1);

    // Five-cycle stall in the middle of a burst
    pulse_start(1'b0);
    c0 = n_ctrl; d0 = n_data;
    send_pixels(16, 100, 0, 1'b0);
    wait_beats(d0, 4);
    bus.wr_full = 1'b1;
    repeat (5) begin
      step();
      check("stall_data_we", 64'(s_data_we), 64'd0);
    end
    bus.wr_full = 1'b0;
    drain(0);
    check("stall_beats", 64'(n_data - d0), 64'd16);
    check("stall_bursts", 64'(n_ctrl - c0), 64'd1);

    // Random frames against the model
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(70, 40));
      e0 = exp_done; f0 = n_done;
      pulse_start(1'($urandom_range(1)));
      send_pixels(n, int'($urandom_range(100, 30)), int'($urandom_range(60)), 1'b1);
      drain(int'($urandom_range(50)));
      check("rnd_done", 64'(n_done - f0), 64'(exp_done - e0));
    end

    // frame_start on the 8th beat, then a second one while still pending
    pulse_start(1'b0);
    c0 = n_ctrl; d0 = n_data;
    send_pixels(16, 100, 0, 1'b0);
    wait_beats(d0, 7);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    check("pend_beat8_active", 64'(s_data_we), 64'd1);
    step();
    check("pend_ready_low", 64'(s_ready), 64'd0);
    check("pend_overflow_clear", 64'(s_overflow), 64'd0);
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    step();
    check("pend_overflow_set", 64'(s_overflow), 64'd1);
    drain(0);
    check("pend_beats", 64'(n_data - d0), 64'd16);
    check("pend_bursts", 64'(n_ctrl - c0), 64'd1);
    send_pixels(16, 100, 0, 1'b0);
    drain(0);
    check("pend_next_addr", 64'(last_addr), 64'(BASE));

    // Reset on the third beat of a burst
    d0 = n_data;
    send_pixels(16, 100, 0, 1'b0);
    wait_beats(d0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    check("abort_data_we", 64'(s_data_we), 64'd0);
    check("abort_ctrl_we", 64'(s_ctrl_we), 64'd0);
    check("abort_ready", 64'(s_ready), 64'd1);
    check("abort_overflow", 64'(s_overflow), 64'd0);
    check("abort_beats", 64'(n_data - d0), 64'd2);
    send_pixels(16, 100, 0, 1'b0);
    drain(0);
    check("abort_next_addr", 64'(last_addr), 64'(BASE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/frame_dram_writer.md
FRAME_DRAM_WRITER -- requirements
Module: frame_dram_writer

Interface
REQ-001 SHALL have parameter X_SIZE, default 1280, pixels per line.
REQ-002 SHALL have parameter Y_SIZE, default 720, lines per frame.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of pixel (0,0).
REQ-004 SHALL have parameter BURST_LEN, default 16, words per DRAM write burst (1..128, power of two, divides X_SIZE*Y_SIZE).
REQ-005 SHALL use a single clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 frame_start  input  1  one-cycle pulse; next accepted pixel is (0,0).
REQ-009 pix_valid  input  1  pix_data valid.
REQ-010 pix_data  input  24  pixel {R[23:16],G[15:8],B[7:0]}.
REQ-011 pix_ready  output  1  pixel accepted when pix_valid && pix_ready.
REQ-012 wr_full  input  1  DRAM write path cannot take ctrl/data this cycle.
REQ-013 data_in  output  36  {strb[35:32], data[31:0]}.
REQ-014 data_we  output  1  data_in write strobe.
REQ-015 ctrl_in  output  40  {len[39:32], addr[31:0]}.
REQ-016 ctrl_we  output  1  ctrl_in write strobe.
REQ-017 frame_done  output  1  one-cycle pulse after last burst of a frame issued.
REQ-018 overflow  output  1  sticky; set when pixel arrives while pix_ready=0 would drop data (never, by construction) or frame_start arrives while one is pending.

Function
REQ-019 SHALL buffer accepted pixels in an internal FIFO of depth 2*BURST_LEN words.
REQ-020 Each word SHALL be {pix_data, 8'h00}; strb SHALL be 4'hF.
REQ-021 pix_ready SHALL be 1 iff FIFO not full, state != FLUSH, and no frame_start pending.
REQ-022 FSM states: IDLE, CMD, DATA, FLUSH.
REQ-023 IDLE -> CMD when FIFO count >= BURST_LEN and wr_full=0 and frame_start not pending.
REQ-024 CMD: ctrl_we=1 for exactly one cycle with len=BURST_LEN-1, addr=BASE_ADDR+word_idx*4; then -> DATA.
REQ-025 DATA: data_we=1 and one FIFO pop per cycle with wr_full=0; wr_full=1 holds data_we=0, no pop; after BURST_LEN beats -> IDLE.
REQ-026 word_idx SHALL advance by BURST_LEN per burst; address arithmetic 32-bit, wrap modulo 2^32.
REQ-027 After burst ending at word_idx = X_SIZE*Y_SIZE, frame_done SHALL pulse on the cycle state returns to IDLE, and word_idx SHALL reset to 0.
REQ-028 Pixels beyond X_SIZE*Y_SIZE in one frame SHALL be accepted (pix_ready=1) and discarded until next frame_start.
REQ-029 frame_start in IDLE SHALL take effect next cycle: -> FLUSH one cycle, FIFO cleared, word_idx=0, pixel counter=0.
REQ-030 frame_start in CMD/DATA SHALL be latched pending; current burst completes fully; then FLUSH as REQ-029.
REQ-031 frame_start with pix_valid same cycle: the pixel SHALL NOT be accepted (pix_ready=0 that cycle).
REQ-032 ctrl_we and data_we SHALL never be asserted in the same cycle.
REQ-033 Partial bursts SHALL never be issued.

Reset
REQ-034 On rst: state=IDLE, FIFO empty, word_idx=0, pixel count=0, pending=0.
REQ-035 Outputs during/after rst: pix_ready=1 (post-reset), data_we=0, ctrl_we=0, frame_done=0, overflow=0, data_in=0, ctrl_in=0.
REQ-036 rst mid-burst SHALL abort immediately; no further ctrl_we/data_we.

Verification
REQ-037 BURST_LEN=16, X_SIZE=32,Y_SIZE=2: frame_start, 64 pixels 0x000001..0x000040 continuous -> 4 ctrl_we with addr 0x00,0x40,0x80,0xC0, len 8'h0F; data 0x00000100..0x00004000 in order; one frame_done.
REQ-038 wr_full held 1 for 5 cycles mid-DATA -> data_we=0 those cycles, beat count and order unchanged, total 16 beats.
REQ-039 frame_start during 8th DATA beat -> remaining 8 beats emitted, then FLUSH; next burst addr=BASE_ADDR.
REQ-040 66 pixels in 64-pixel frame -> last 2 discarded, no 5th ctrl_we; frame_done once.
REQ-041 FIFO fill with wr_full=1 permanently -> pix_ready drops after 32 pixels, no data lost after wr_full released.
REQ-042 rst during DATA beat 3 -> next cycle data_we=0, ctrl_we=0, pix_ready=1, next burst addr=BASE_ADDR.
